// File: rtl/sdram_para.sv
// Shared SDRAM scheduler definitions: default burst/frame sizes, FSM encoding
// and address packing used by the request scheduler and its address counters.
package sdram_para;

    localparam logic [9:0]  BURST_LEN_DEF   = 10'd512;
    localparam logic [23:0] FRAME_WORDS_DEF = 24'd786432;
    localparam int          OFFSET_W        = 23;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_BUSY,
        RD_REQ,
        RD_BUSY
    } sched_state_t;

    typedef enum logic {
        SIDE_WR = 1'b0,
        SIDE_RD = 1'b1
    } side_t;

    // SDRAM address is the ping-pong bank bit on top of the in-frame offset
    function automatic logic [23:0] make_addr(input logic bank, input logic [OFFSET_W-1:0] offset);
        return {bank, offset};
    endfunction

endpackage

// File: rtl/sdram_addr_gen.sv
// Per-side frame offset counter: steps by one burst when a burst completes,
// wraps at the end of the frame and can be zeroed by a pending frame load.
module sdram_addr_gen
    import sdram_para::*;
#(
    parameter logic [9:0]  BURST_LEN   = BURST_LEN_DEF,
    parameter logic [23:0] FRAME_WORDS = FRAME_WORDS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                advance,
    input  logic                clear,
    output logic [OFFSET_W-1:0] offset,
    output logic                wrap
);

    logic [23:0] next_sum;

    assign next_sum = {1'b0, offset} + {14'd0, BURST_LEN};
    assign wrap     = advance && (next_sum == FRAME_WORDS);

    // advance only happens in BUSY and clear only in IDLE, so they never collide
    always_ff @(posedge clk) begin
        if (rst) begin
            offset <= '0;
        end else if (advance) begin
            offset <= wrap ? '0 : next_sum[OFFSET_W-1:0];
        end else if (clear) begin
            offset <= '0;
        end
    end

endmodule

// File: rtl/sdram_req_sched.sv
// SDRAM request scheduler: arbitrates write-FIFO drain and read-FIFO refill
// bursts and manages the ping-pong frame buffer addresses for both sides.
module sdram_req_sched
    import sdram_para::*;
#(
    parameter logic [9:0]  BURST_LEN   = BURST_LEN_DEF,
    parameter logic [23:0] FRAME_WORDS = FRAME_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sdram_init_done,
    input  logic [9:0]  wr_fifo_level,
    input  logic [9:0]  rd_fifo_level,
    input  logic        rd_enable,
    input  logic        wr_load,
    input  logic        rd_load,
    output logic        sdram_wr_req,
    output logic        sdram_rd_req,
    input  logic        sdram_wr_ack,
    input  logic        sdram_rd_ack,
    output logic [23:0] sdram_wr_addr,
    output logic [23:0] sdram_rd_addr,
    output logic [9:0]  sdram_wr_burst,
    output logic [9:0]  sdram_rd_burst,
    output logic        wr_bank,
    output logic        rd_bank
);

    sched_state_t        state, state_next;
    side_t               last_served;
    logic                wr_pend, rd_pend;
    logic                rd_bank_next;
    logic                wr_elig, rd_elig;
    logic                wr_adv, rd_adv;
    logic                wr_clear, rd_clear;
    logic                wr_wrap, rd_wrap;
    logic [OFFSET_W-1:0] wr_offset, rd_offset;

    assign wr_elig = (wr_fifo_level >= BURST_LEN);
    assign rd_elig = rd_enable && (rd_fifo_level < BURST_LEN);

    assign sdram_wr_addr  = make_addr(wr_bank, wr_offset);
    assign sdram_rd_addr  = make_addr(rd_bank, rd_offset);
    assign sdram_wr_burst = BURST_LEN;
    assign sdram_rd_burst = BURST_LEN;

    sdram_addr_gen #(
        .BURST_LEN  (BURST_LEN),
        .FRAME_WORDS(FRAME_WORDS)
    ) u_wr_addr (
        .clk    (clk),
        .rst    (rst),
        .advance(wr_adv),
        .clear  (wr_clear),
        .offset (wr_offset),
        .wrap   (wr_wrap)
    );

    sdram_addr_gen #(
        .BURST_LEN  (BURST_LEN),
        .FRAME_WORDS(FRAME_WORDS)
    ) u_rd_addr (
        .clk    (clk),
        .rst    (rst),
        .advance(rd_adv),
        .clear  (rd_clear),
        .offset (rd_offset),
        .wrap   (rd_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pending frame loads are consumed only in IDLE so an active burst keeps its address
    always_comb begin
        state_next = state;
        wr_adv     = 1'b0;
        rd_adv     = 1'b0;
        wr_clear   = 1'b0;
        rd_clear   = 1'b0;
        case (state)
            IDLE: begin
                wr_clear = wr_pend;
                rd_clear = rd_pend;
                if (sdram_init_done) begin
                    if (wr_elig && rd_elig) begin
                        state_next = (last_served == SIDE_RD) ? WR_REQ : RD_REQ;
                    end else if (wr_elig) begin
                        state_next = WR_REQ;
                    end else if (rd_elig) begin
                        state_next = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (sdram_wr_ack) state_next = WR_BUSY;
            end
            WR_BUSY: begin
                if (!sdram_wr_ack) begin
                    wr_adv     = 1'b1;
                    state_next = IDLE;
                end
            end
            RD_REQ: begin
                if (sdram_rd_ack) state_next = RD_BUSY;
            end
            RD_BUSY: begin
                if (!sdram_rd_ack) begin
                    rd_adv     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sdram_wr_req <= 1'b0;
            sdram_rd_req <= 1'b0;
            last_served  <= SIDE_RD;
            wr_pend      <= 1'b0;
            rd_pend      <= 1'b0;
        end else begin
            sdram_wr_req <= (state_next == WR_REQ);
            sdram_rd_req <= (state_next == RD_REQ);
            if (state == IDLE && state_next == WR_REQ) begin
                last_served <= SIDE_WR;
            end else if (state == IDLE && state_next == RD_REQ) begin
                last_served <= SIDE_RD;
            end
            wr_pend <= wr_load | (wr_pend & (state != IDLE));
            rd_pend <= rd_load | (rd_pend & (state != IDLE));
        end
    end

    // A write wrap hands the finished buffer to the reader; the reader only
    // switches at its own wrap so a displayed frame never mixes buffers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b1;
            rd_bank_next <= 1'b1;
        end else begin
            if (wr_wrap) begin
                wr_bank      <= ~wr_bank;
                rd_bank_next <= wr_bank;
            end
            if (rd_wrap) begin
                rd_bank <= rd_bank_next;
            end
        end
    end

endmodule

// File: tb/tb_sdram_req_sched.sv
// Self-checking bench for sdram_req_sched: directed scenarios plus randomized
// bursts checked against a transaction-level model of the scheduling rules.
module tb_sdram_req_sched;

    localparam int BL      = 512;
    localparam int FRAME_S = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        sdram_init_done;
    logic [9:0]  wr_fifo_level, rd_fifo_level;
    logic        rd_enable, wr_load, rd_load;
    logic        sdram_wr_ack, sdram_rd_ack;

    logic        sdram_wr_req, sdram_rd_req;
    logic [23:0] sdram_wr_addr, sdram_rd_addr;
    logic [9:0]  sdram_wr_burst, sdram_rd_burst;
    logic        wr_bank, rd_bank;

    logic        b_wr_req, b_rd_req;
    logic [23:0] b_wr_addr, b_rd_addr;
    logic [9:0]  b_wr_burst, b_rd_burst;
    logic        b_wr_bank, b_rd_bank;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Small-frame instance exercises wraps; default instance shows plain offsets
    sdram_req_sched #(.BURST_LEN(10'd512), .FRAME_WORDS(24'd1024)) u_dut (
        .clk(clk), .rst(rst), .sdram_init_done(sdram_init_done),
        .wr_fifo_level(wr_fifo_level), .rd_fifo_level(rd_fifo_level),
        .rd_enable(rd_enable), .wr_load(wr_load), .rd_load(rd_load),
        .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
        .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack),
        .sdram_wr_addr(sdram_wr_addr), .sdram_rd_addr(sdram_rd_addr),
        .sdram_wr_burst(sdram_wr_burst), .sdram_rd_burst(sdram_rd_burst),
        .wr_bank(wr_bank), .rd_bank(rd_bank)
    );

    sdram_req_sched u_dut_big (
        .clk(clk), .rst(rst), .sdram_init_done(sdram_init_done),
        .wr_fifo_level(wr_fifo_level), .rd_fifo_level(rd_fifo_level),
        .rd_enable(rd_enable), .wr_load(wr_load), .rd_load(rd_load),
        .sdram_wr_req(b_wr_req), .sdram_rd_req(b_rd_req),
        .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack),
        .sdram_wr_addr(b_wr_addr), .sdram_rd_addr(b_rd_addr),
        .sdram_wr_burst(b_wr_burst), .sdram_rd_burst(b_rd_burst),
        .wr_bank(b_wr_bank), .rd_bank(b_rd_bank)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; sdram_init_done = 1'b1;
        wr_fifo_level = '0; rd_fifo_level = '0; rd_enable = 1'b0;
        wr_load = 1'b0; rd_load = 1'b0; sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic wait_req(input bit want_wr, output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        while (waited < 8) begin
            tick;
            waited++;
            if (want_wr ? sdram_wr_req : sdram_rd_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic finish_burst(input bit is_wr, input int busy_cycles);
        if (is_wr) sdram_wr_ack = 1'b1; else sdram_rd_ack = 1'b1;
        tick;
        repeat (busy_cycles) tick;
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        int reqs;
        do_reset;
        checks++; if ({sdram_wr_req, sdram_rd_req} !== 2'b00) begin failures++; $display("[TB] FAIL reset_req: got %b expected 00", {sdram_wr_req, sdram_rd_req}); end
        checks++; if (sdram_wr_addr !== 24'h000000) begin failures++; $display("[TB] FAIL reset_wr_addr: got %h expected 000000", sdram_wr_addr); end
        checks++; if (sdram_rd_addr !== 24'h800000) begin failures++; $display("[TB] FAIL reset_rd_addr: got %h expected 800000", sdram_rd_addr); end
        checks++; if ({wr_bank, rd_bank} !== 2'b01) begin failures++; $display("[TB] FAIL reset_banks: got %b expected 01", {wr_bank, rd_bank}); end
        checks++; if ({sdram_wr_burst, sdram_rd_burst, b_wr_burst, b_rd_burst} !== {4{10'd512}}) begin failures++; $display("[TB] FAIL burst_len: got %0d %0d %0d %0d expected 512", sdram_wr_burst, sdram_rd_burst, b_wr_burst, b_rd_burst); end
        checks++; if ({b_wr_req, b_rd_req, b_wr_bank, b_rd_bank, b_wr_addr, b_rd_addr} !== {4'b0001, 24'h000000, 24'h800000}) begin failures++; $display("[TB] FAIL reset_big: got %b%b%b%b %h %h", b_wr_req, b_rd_req, b_wr_bank, b_rd_bank, b_wr_addr, b_rd_addr); end
        // just below the write threshold and just at the read threshold: nobody eligible
        wr_fifo_level = 10'd511; rd_enable = 1'b1; rd_fifo_level = 10'd512;
        reqs = 0;
        repeat (6) begin tick; if (sdram_wr_req || sdram_rd_req) reqs++; end
        checks++; if (reqs !== 0) begin failures++; $display("[TB] FAIL threshold_idle: got %0d request cycles expected 0", reqs); end
    endtask

    task automatic test_write_only;
        bit ok; int waited; int extra;
        do_reset;
        wr_fifo_level = 10'd512;
        wait_req(1'b1, ok, waited);
        checks++; if (!ok || waited !== 1) begin failures++; $display("[TB] FAIL wr_latency: got %0d cycles (seen %0b) expected 1", waited, ok); end
        checks++; if (b_wr_addr !== 24'h000000) begin failures++; $display("[TB] FAIL wr_first_addr: got %h expected 000000", b_wr_addr); end
        sdram_wr_ack = 1'b1;
        extra = 0;
        repeat (BL) begin tick; if (sdram_wr_req || sdram_rd_req) extra++; end
        sdram_wr_ack = 1'b0;
        tick;
        checks++; if (extra !== 0) begin failures++; $display("[TB] FAIL wr_single_req: got %0d request cycles during ack expected 0", extra); end
        wait_req(1'b1, ok, waited);
        checks++; if (!ok || b_wr_addr !== 24'h000200) begin failures++; $display("[TB] FAIL wr_next_addr: got %h (seen %0b) expected 000200", b_wr_addr, ok); end
    endtask

    task automatic test_init_gating;
        bit ok; int waited; int reqs;
        do_reset;
        sdram_init_done = 1'b0;
        wr_fifo_level = 10'd600;
        reqs = 0;
        repeat (10) begin tick; if (sdram_wr_req || sdram_rd_req) reqs++; end
        checks++; if (reqs !== 0) begin failures++; $display("[TB] FAIL init_gate: got %0d request cycles expected 0", reqs); end
        sdram_init_done = 1'b1;
        wait_req(1'b1, ok, waited);
        checks++; if (!ok || waited !== 1) begin failures++; $display("[TB] FAIL init_latency: got %0d cycles (seen %0b) expected 1", waited, ok); end
    endtask

    task automatic test_arbitration;
        bit got_wr; bit seen; int overlap;
        do_reset;
        wr_fifo_level = 10'd700; rd_enable = 1'b1; rd_fifo_level = 10'd100;
        overlap = 0;
        for (int g = 0; g < 4; g++) begin
            seen = 1'b0; got_wr = 1'b0;
            for (int t = 0; t < 8; t++) begin
                tick;
                if (sdram_wr_req && sdram_rd_req) overlap++;
                if (sdram_wr_req || sdram_rd_req) begin seen = 1'b1; got_wr = sdram_wr_req; break; end
            end
            checks++; if (!seen || got_wr !== ((g % 2) == 0)) begin failures++; $display("[TB] FAIL arb_order grant %0d: got wr=%0b (seen %0b) expected wr=%0b", g, got_wr, seen, (g % 2) == 0); end
            finish_burst(got_wr, 2);
        end
        checks++; if (overlap !== 0) begin failures++; $display("[TB] FAIL arb_overlap: got %0d expected 0", overlap); end
    endtask

    task automatic test_wrap;
        bit ok; int waited;
        logic [23:0] exp_addr;
        do_reset;
        for (int b = 0; b < 2; b++) begin
            wr_fifo_level = 10'd512;
            wait_req(1'b1, ok, waited);
            exp_addr = 24'(b * BL);
            checks++; if (!ok || sdram_wr_addr !== exp_addr) begin failures++; $display("[TB] FAIL wrap_wr_addr %0d: got %h expected %h", b, sdram_wr_addr, exp_addr); end
            finish_burst(1'b1, 1);
            wr_fifo_level = '0;
        end
        checks++; if ({sdram_wr_addr, wr_bank, rd_bank} !== {24'h800000, 2'b11}) begin failures++; $display("[TB] FAIL wrap_wr_bank: got addr %h banks %b%b expected 800000 11", sdram_wr_addr, wr_bank, rd_bank); end
        for (int b = 0; b < 2; b++) begin
            rd_enable = 1'b1;
            wait_req(1'b0, ok, waited);
            exp_addr = {1'b1, 23'(b * BL)};
            checks++; if (!ok || sdram_rd_addr !== exp_addr) begin failures++; $display("[TB] FAIL wrap_rd_addr %0d: got %h expected %h", b, sdram_rd_addr, exp_addr); end
            finish_burst(1'b0, 1);
            rd_enable = 1'b0;
            checks++; if (rd_bank !== (b == 0)) begin failures++; $display("[TB] FAIL wrap_rd_bank %0d: got %b expected %b", b, rd_bank, b == 0); end
        end
        // second frame: last write burst ends together with a load pulse
        wr_fifo_level = 10'd512;
        wait_req(1'b1, ok, waited);
        finish_burst(1'b1, 1);
        wait_req(1'b1, ok, waited);
        checks++; if (!ok || sdram_wr_addr !== 24'h800200) begin failures++; $display("[TB] FAIL wrap_wr_addr2: got %h expected 800200", sdram_wr_addr); end
        sdram_wr_ack = 1'b1; tick; tick;
        sdram_wr_ack = 1'b0; wr_load = 1'b1; tick;
        wr_load = 1'b0; wr_fifo_level = '0;
        checks++; if ({sdram_wr_addr, wr_bank} !== {24'h000000, 1'b0}) begin failures++; $display("[TB] FAIL wrap_with_load: got addr %h bank %b expected 000000 0", sdram_wr_addr, wr_bank); end
        for (int b = 0; b < 2; b++) begin
            rd_enable = 1'b1;
            wait_req(1'b0, ok, waited);
            finish_burst(1'b0, 1);
            rd_enable = 1'b0;
        end
        checks++; if (rd_bank !== 1'b1) begin failures++; $display("[TB] FAIL wrap_rd_bank_frame2: got %b expected 1", rd_bank); end
    endtask

    task automatic test_load_mid_burst;
        bit ok; int waited;
        do_reset;
        wr_fifo_level = 10'd512;
        wait_req(1'b1, ok, waited);
        finish_burst(1'b1, 1);
        wait_req(1'b1, ok, waited);
        checks++; if (!ok || b_wr_addr !== 24'h000200) begin failures++; $display("[TB] FAIL load_pre_addr: got %h expected 000200", b_wr_addr); end
        sdram_wr_ack = 1'b1; tick; tick;
        wr_load = 1'b1; tick;
        wr_load = 1'b0;
        checks++; if (b_wr_addr !== 24'h000200) begin failures++; $display("[TB] FAIL load_active_addr: got %h expected 000200", b_wr_addr); end
        tick;
        sdram_wr_ack = 1'b0; tick;
        wait_req(1'b1, ok, waited);
        checks++; if (!ok || b_wr_addr !== 24'h000000) begin failures++; $display("[TB] FAIL load_next_addr: got %h expected 000000", b_wr_addr); end
        checks++; if (sdram_wr_addr !== 24'h800000) begin failures++; $display("[TB] FAIL load_small_addr: got %h expected 800000", sdram_wr_addr); end
    endtask

    task automatic test_reset_mid_burst;
        bit ok; int waited;
        do_reset;
        wr_fifo_level = 10'd512;
        for (int b = 0; b < 2; b++) begin
            wait_req(1'b1, ok, waited);
            finish_burst(1'b1, 1);
        end
        wr_fifo_level = '0; rd_enable = 1'b1;
        wait_req(1'b0, ok, waited);
        finish_burst(1'b0, 1);
        wait_req(1'b0, ok, waited);
        checks++; if (!ok || sdram_rd_addr !== 24'h800200 || wr_bank !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_setup: got rd %h wr_bank %b expected 800200 1", sdram_rd_addr, wr_bank); end
        sdram_rd_ack = 1'b1; tick; tick;
        rd_enable = 1'b0; rst = 1'b1; tick;
        checks++; if ({sdram_wr_req, sdram_rd_req, wr_bank, rd_bank} !== 4'b0001) begin failures++; $display("[TB] FAIL rstmid_ctrl: got req %b%b banks %b%b expected 00 01", sdram_wr_req, sdram_rd_req, wr_bank, rd_bank); end
        checks++; if ({sdram_wr_addr, sdram_rd_addr} !== {24'h000000, 24'h800000}) begin failures++; $display("[TB] FAIL rstmid_addr: got %h %h expected 000000 800000", sdram_wr_addr, sdram_rd_addr); end
        rst = 1'b0; sdram_rd_ack = 1'b0;
    endtask

    task automatic test_random;
        int m_wr_off, m_rd_off;
        bit m_wr_bank, m_rd_bank, m_rd_next, m_last_wr, m_wr_pend, m_rd_pend;
        bit we, re, exp_wr, seen, got_wr, lw, lr;
        int waited, hold, busy, lp;
        logic [1:0] sel;
        logic [23:0] exp_addr, got_addr;
        do_reset;
        m_wr_off = 0; m_rd_off = 0; m_wr_bank = 0; m_rd_bank = 1; m_rd_next = 1;
        m_last_wr = 0; m_wr_pend = 0; m_rd_pend = 0;
        for (int it = 0; it < 150; it++) begin
            sel = 2'($urandom_range(1, 3));
            we = sel[0]; re = sel[1];
            wr_fifo_level = we ? 10'($urandom_range(512, 1023)) : 10'($urandom_range(0, 511));
            if (re) begin
                rd_enable = 1'b1; rd_fifo_level = 10'($urandom_range(0, 511));
            end else if ($urandom_range(0, 1) == 1) begin
                rd_enable = 1'b0; rd_fifo_level = 10'($urandom_range(0, 1023));
            end else begin
                rd_enable = 1'b1; rd_fifo_level = 10'($urandom_range(512, 1023));
            end
            if (m_wr_pend) begin m_wr_off = 0; m_wr_pend = 0; end
            if (m_rd_pend) begin m_rd_off = 0; m_rd_pend = 0; end
            exp_wr = (we && re) ? !m_last_wr : we;
            exp_addr = exp_wr ? {m_wr_bank, 23'(m_wr_off)} : {m_rd_bank, 23'(m_rd_off)};
            seen = 1'b0; got_wr = 1'b0; waited = 0;
            for (int t = 0; t < 8; t++) begin
                tick; waited++;
                if (sdram_wr_req || sdram_rd_req) begin seen = 1'b1; got_wr = sdram_wr_req; break; end
            end
            checks++;
            if (!seen || waited !== 1) begin
                failures++; $display("[TB] FAIL rnd_latency it %0d: got %0d cycles (seen %0b) expected 1", it, waited, seen);
                break;
            end
            got_addr = got_wr ? sdram_wr_addr : sdram_rd_addr;
            checks++; if (got_wr !== exp_wr || sdram_wr_req === sdram_rd_req) begin failures++; $display("[TB] FAIL rnd_side it %0d: got req %b%b expected wr=%0b", it, sdram_wr_req, sdram_rd_req, exp_wr); end
            checks++; if (got_addr !== exp_addr) begin failures++; $display("[TB] FAIL rnd_addr it %0d: got %h expected %h", it, got_addr, exp_addr); end
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                tick;
                got_addr = exp_wr ? sdram_wr_addr : sdram_rd_addr;
                checks++; if ({sdram_wr_req, sdram_rd_req} !== {exp_wr, !exp_wr} || got_addr !== exp_addr) begin failures++; $display("[TB] FAIL rnd_hold it %0d: got req %b%b addr %h expected addr %h", it, sdram_wr_req, sdram_rd_req, got_addr, exp_addr); end
            end
            if (exp_wr) sdram_wr_ack = 1'b1; else sdram_rd_ack = 1'b1;
            tick;
            checks++; if ({sdram_wr_req, sdram_rd_req} !== 2'b00) begin failures++; $display("[TB] FAIL rnd_req_drop it %0d: got %b%b expected 00", it, sdram_wr_req, sdram_rd_req); end
            busy = $urandom_range(0, 4);
            lp = (busy > 0) ? $urandom_range(0, busy - 1) : -1;
            lw = ($urandom_range(0, 2) == 0); lr = ($urandom_range(0, 2) == 0);
            for (int j = 0; j < busy; j++) begin
                if (j == lp) begin wr_load = lw; rd_load = lr; end
                tick;
                wr_load = 1'b0; rd_load = 1'b0;
            end
            if (lp >= 0) begin m_wr_pend |= lw; m_rd_pend |= lr; end
            sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
            tick;
            m_last_wr = exp_wr;
            if (exp_wr) begin
                m_wr_off += BL;
                if (m_wr_off == FRAME_S) begin
                    m_wr_off = 0; m_rd_next = m_wr_bank; m_wr_bank = !m_wr_bank;
                end
            end else begin
                m_rd_off += BL;
                if (m_rd_off == FRAME_S) begin
                    m_rd_off = 0; m_rd_bank = m_rd_next;
                end
            end
            checks++; if ({wr_bank, rd_bank} !== {m_wr_bank, m_rd_bank}) begin failures++; $display("[TB] FAIL rnd_banks it %0d: got %b%b expected %b%b", it, wr_bank, rd_bank, m_wr_bank, m_rd_bank); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset;
        test_write_only;
        test_init_gating;
        test_arbitration;
        test_wrap;
        test_load_mid_burst;
        test_reset_mid_burst;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_req_sched.md
SDRAM_REQ_SCHED -- requirements
Module: sdram_req_sched

Interface
REQ-001 SHALL have parameter BURST_LEN, default 10'd512, meaning the words per SDRAM burst request.
REQ-002 SHALL have parameter FRAME_WORDS, default 24'd786432, meaning the words per frame region; it is a multiple of BURST_LEN.
REQ-003 SHALL have port clk, input, 1 bit: the SDRAM controller clock (100 MHz); the block uses one clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port sdram_init_done, input, 1 bit: the SDRAM initialisation-complete flag.
REQ-006 SHALL have ports wr_fifo_level and rd_fifo_level, input, 10 bits each: the words held in the write FIFO and in the read FIFO.
REQ-007 SHALL have port rd_enable, input, 1 bit: the display read path is active.
REQ-008 SHALL have ports wr_load and rd_load, input, 1 bit each: single-cycle frame-start pulses.
REQ-009 SHALL have ports sdram_wr_req and sdram_rd_req, output, 1 bit each: the request strobes to the controller.
REQ-010 SHALL have ports sdram_wr_ack and sdram_rd_ack, input, 1 bit each: each is high for the duration of its accepted burst.
REQ-011 SHALL have ports sdram_wr_addr and sdram_rd_addr, output, 24 bits each: {bank bit, 23-bit offset}.
REQ-012 SHALL have ports sdram_wr_burst and sdram_rd_burst, output, 10 bits each: constant BURST_LEN.
REQ-013 SHALL have ports wr_bank and rd_bank, output, 1 bit each: the current ping-pong frame buffers.

Function
REQ-014 SHALL implement FSM states IDLE, WR_REQ, WR_BUSY, RD_REQ, RD_BUSY.
REQ-015 SHALL remain in IDLE while sdram_init_done=0.
REQ-016 SHALL treat the write side as eligible when wr_fifo_level >= BURST_LEN.
REQ-017 SHALL treat the read side as eligible when rd_enable=1 and rd_fifo_level < BURST_LEN.
REQ-018 SHALL, when both sides are eligible in IDLE, serve the side not served last; write wins the first tie after reset.
REQ-019 SHALL hold the request registered high from the cycle after the IDLE decision until ack=1 is sampled (WR_REQ/RD_REQ), then drop it the next cycle.
REQ-020 SHALL stay in WR_BUSY/RD_BUSY while ack=1, and on the ack 1->0 edge advance that side's offset by BURST_LEN and return to IDLE.
REQ-021 SHALL, when the advanced offset equals FRAME_WORDS, wrap it to 0; on a write wrap it toggles wr_bank and sets rd_bank_next to the old wr_bank.
REQ-022 SHALL load rd_bank from rd_bank_next only on a read wrap, so a read frame never mixes buffers.
REQ-023 SHALL latch wr_load/rd_load into pending flags; each flag zeroes its offset on the next IDLE cycle and is then cleared. A load during BUSY is never lost and never corrupts the active burst's address.
REQ-024 SHALL, when a load pulse and a wrap occur in the same cycle, zero the offset with the bank toggle still applied.
REQ-025 SHALL keep the address and burst outputs stable while the request is high.
REQ-026 SHALL have a latency of 1 cycle from eligibility sampled in IDLE to the request rising.
REQ-027 SHALL never assert sdram_wr_req and sdram_rd_req simultaneously.

Reset
REQ-028 SHALL, on rst=1 at a clk edge, enter IDLE with both requests 0, offsets 0, wr_bank=0, rd_bank=1, rd_bank_next=1, pending flags 0, and last-served=read.
REQ-029 SHALL, on rst mid-burst, drop the request on the next cycle, regardless of ack.

Structure
REQ-030 SHALL take the state encoding and the BURST_LEN/FRAME_WORDS defaults from the shared sdram package (sdram_para); no sub-module is required.
REQ-031 MAY factor the per-side offset/bank counter into one sub-module, sdram_addr_gen, instantiated twice.

Verification
REQ-032 SHALL cover write only: wr_fifo_level=512 with ack high 512 cycles -> one wr_req, wr_addr 0x000000, next addr 0x000200.
REQ-033 SHALL cover arbitration: both sides eligible continuously -> requests alternate W,R,W,R, with no overlap.
REQ-034 SHALL cover wrap: FRAME_WORDS=1024, four write bursts -> after the 2nd burst the offset is 0, wr_bank=1 and rd_bank_next=0; rd_bank changes only after the 2nd read burst completes.
REQ-035 SHALL cover load mid-burst: wr_load during WR_BUSY at offset 0x200 -> the active addr is unchanged and the next wr_addr is 0x000000.
REQ-036 SHALL cover init gating: sdram_init_done=0 with wr_fifo_level=600 -> no requests; init_done rising -> wr_req one cycle later.
REQ-037 SHALL cover reset mid-burst: rst during RD_BUSY -> requests 0 the next cycle, banks 0/1, offsets 0.
